// File: rtl/instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit
//
// IF-stage front end. Owns the fetch PC, issues word requests to instruction
// memory (valid/ready request channel, in-order responses), buffers returned
// instructions in a small FIFO and presents the head instruction plus its PC to
// the IF/ID register. A redirect flushes the buffer and arranges for responses
// to requests already in flight to be discarded.
//
// Ports:
//   clk              clock, all state on the rising edge
//   rst              asynchronous active-low reset
//   imem_req_valid   request valid (credit limited, withdrawn on redirect)
//   imem_req_addr    word-aligned fetch address (the fetch PC register)
//   imem_req_ready   memory accepts the request this cycle
//   imem_resp_valid  response valid, in order, one per accepted request
//   imem_resp_data   instruction word
//   redirect_valid   flush and restart fetch at redirect_pc
//   redirect_pc      new fetch address, bits [1:0] forced to zero
//   instr_out        head instruction, NOP when empty
//   instr_pc_out     PC of head instruction, 0 when empty
//   instr_valid      FIFO non-empty
//   instr_take       consumer pops the head this cycle
// -----------------------------------------------------------------------------
module instr_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        instr_valid,
    input  logic        instr_take
);

    localparam int unsigned CntW     = $clog2(DEPTH + 1);
    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);
    localparam logic [31:0] Nop      = 32'h0000_0013;

    logic [31:0]     fpc_q, fpc_d;
    // PC of the next response that will actually be pushed; reloaded on
    // redirect so discarded responses never advance it.
    logic [31:0]     rpc_q, rpc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic        accept;
    logic        resp_drop;
    logic        push;
    logic        pop;
    logic [CntW:0] credit_used;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign credit_used      = {1'b0, count_q} + {1'b0, outstanding_q};

    // Request is also gated by rst so it reads 0 while reset is held.
    assign imem_req_valid = rst && !redirect_valid && (credit_used < DepthLim);
    assign imem_req_addr  = fpc_q;

    assign accept    = imem_req_valid && imem_req_ready;
    // A response in a redirect cycle belongs to the old stream by definition.
    assign resp_drop = imem_resp_valid && (redirect_valid || (discard_q != '0));
    assign push      = imem_resp_valid && !resp_drop;
    assign pop       = instr_take && (count_q != '0) && !redirect_valid;

    always_comb begin
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) begin
            outstanding_d = outstanding_d + CntW'(1);
        end
        if (imem_resp_valid) begin
            outstanding_d = outstanding_d - CntW'(1);
        end

        if (redirect_valid) begin
            // No request is accepted in a redirect cycle, so everything still
            // in flight after this edge belongs to the old stream.
            fpc_d     = redirect_aligned;
            rpc_d     = redirect_aligned;
            discard_d = outstanding_q - CntW'(imem_resp_valid);
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end else begin
            if (accept) begin
                fpc_d = fpc_q + 32'd4;
            end
            if (resp_drop) begin
                discard_d = discard_q - CntW'(1);
            end
            if (push) begin
                rpc_d    = rpc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                count_d  = count_d + CntW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                count_d  = count_d - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_resp_data;
            pc_mem[wr_ptr_q]   <= rpc_q;
        end
    end

    always_comb begin
        instr_valid  = (count_q != '0);
        instr_out    = Nop;
        instr_pc_out = '0;
        if (instr_valid) begin
            instr_out    = data_mem[rd_ptr_q];
            instr_pc_out = pc_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for instr_prefetch_unit. A memory model answers accepted requests
// in order after a programmable latency; a reference model of the fetch stream
// (a PC counter that restarts on redirect/reset) pushes the expected {pc, data}
// of every accepted request into a scoreboard queue, and a separate monitor
// checks the head of the DUT buffer against it every cycle.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_valid;
    logic        instr_take = 1'b0;

    instr_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_out       (instr_out),
        .instr_pc_out    (instr_pc_out),
        .instr_valid     (instr_valid),
        .instr_take      (instr_take)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mreq_t       pending[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] acc_log[$];

    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned mem_lat = 1;
    bit          lat_rand = 1'b0;
    int unsigned ready_pct = 100;
    int          n_acc = 0;
    int          n_pops = 0;
    logic [31:0] model_fpc = RESET_PC;

    int n_vec = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory model + reference fetch-stream model.
    always begin
        int unsigned due;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            pending.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            check32("resp_with_outstanding", 32'(dut.outstanding_q != '0), 32'd1);
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_fn(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        #4;
        if (!rst) begin
            exp_q.delete();
            model_fpc = RESET_PC;
        end else begin
            if (redirect_valid) begin
                check32("req_withdrawn", 32'(imem_req_valid), 32'd0);
                exp_q.delete();
                model_fpc = {redirect_pc[31:2], 2'b00};
            end
            if (imem_req_valid && imem_req_ready) begin
                check32("req_addr", imem_req_addr, model_fpc);
                due = cyc + (lat_rand ? $urandom_range(4, 1) : mem_lat);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pending.push_back('{addr: imem_req_addr, due: due});
                exp_q.push_back('{pc: model_fpc, data: mem_fn(model_fpc)});
                acc_log.push_back(imem_req_addr);
                n_acc++;
                model_fpc = model_fpc + 32'd4;
                check32("credit_bound", 32'(pending.size() <= DEPTH), 32'd1);
            end
        end
    end

    // Monitor: compares the buffer head against the scoreboard every cycle.
    always begin
        @(negedge clk);
        #4;
        if (rst && !redirect_valid) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL head_unexpected: got pc %h, expected no instruction", instr_pc_out);
                end else begin
                    check32("head_pc", instr_pc_out, exp_q[0].pc);
                    check32("head_data", instr_out, exp_q[0].data);
                    if (instr_take) begin
                        void'(exp_q.pop_front());
                        pop_log.push_back(instr_pc_out);
                        n_pops++;
                    end
                end
            end else begin
                check32("empty_instr", instr_out, NOP);
                check32("empty_pc", instr_pc_out, 32'h0);
            end
        end
    end

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        pop_log.delete();
        acc_log.delete();
        n_acc = 0;
        @(negedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [31:0] q[$], input int idx,
                             input logic [31:0] req);
        if (q.size() <= idx) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: got %0d entries, expected entry %0d = %h", name, q.size(), idx, req);
        end else begin
            check32(name, q[idx], req);
        end
    endtask

    initial begin
        int p0;
        bit found;
        #2;
        check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check32("rst_req_addr", imem_req_addr, RESET_PC);
        check32("rst_instr_valid", 32'(instr_valid), 32'd0);
        check32("rst_instr_out", instr_out, NOP);
        check32("rst_instr_pc", instr_pc_out, 32'h0);

        // Streaming, 1-cycle memory, consumer always taking.
        instr_take = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #2 check32("start_c0_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #3 check32("start_c1_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #3 check32("start_c2_valid", 32'(instr_valid), 32'd1);
        repeat (4) @(negedge clk);
        #1 p0 = n_pops;
        repeat (20) @(negedge clk);
        #1 check32("throughput", 32'(n_pops - p0), 32'd20);
        check_log("stream_pc0", pop_log, 0, 32'h0);
        check_log("stream_pc1", pop_log, 1, 32'h4);
        check_log("stream_pc2", pop_log, 2, 32'h8);

        // Stalled consumer: exactly DEPTH requests, then drain without gaps.
        instr_take = 1'b0;
        do_redirect(32'h0);
        repeat (19) @(negedge clk);
        #2;
        check32("stall_accepts", 32'(n_acc), DEPTH);
        check32("stall_valid", 32'(instr_valid), 32'd1);
        check32("stall_head_pc", instr_pc_out, 32'h0);
        @(negedge clk);
        #1 instr_take = 1'b1;
        p0 = n_pops;
        repeat (8) @(negedge clk);
        #1 check32("drain_no_gap", 32'(n_pops - p0), 32'd8);
        for (int i = 0; i < 5; i++) check_log("drain_pc", pop_log, i, 32'(4 * i));

        // 3-cycle memory, redirect with 3 requests in flight.
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1 if (pending.size() + int'(imem_resp_valid) >= 3) found = 1'b1;
        end
        check32("three_in_flight", 32'(found), 32'd1);
        do_redirect(32'h0000_0102);
        repeat (15) @(negedge clk);
        #1 check_log("redirect_first_pc", pop_log, 0, 32'h100);

        // Redirect coinciding with a response and a take.
        mem_lat = 1;
        repeat (3) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1 if (imem_resp_valid && instr_valid) found = 1'b1;
        end
        check32("collide_found", 32'(found), 32'd1);
        do_redirect(32'h0000_0300);
        #2;
        check32("collide_valid_low", 32'(instr_valid), 32'd0);
        check32("collide_req_valid", 32'(imem_req_valid), 32'd1);
        check32("collide_req_addr", imem_req_addr, 32'h0000_0300);
        repeat (10) @(negedge clk);
        #1 check_log("collide_first_pc", pop_log, 0, 32'h300);

        // Fetch PC wrap-around.
        do_redirect(32'hFFFF_FFF8);
        repeat (10) @(negedge clk);
        #1;
        check_log("wrap_addr0", acc_log, 0, 32'hFFFF_FFF8);
        check_log("wrap_addr1", acc_log, 1, 32'hFFFF_FFFC);
        check_log("wrap_addr2", acc_log, 2, 32'h0000_0000);
        check_log("wrap_pop2", pop_log, 2, 32'h0000_0000);

        // Randomised traffic: stalls, backpressure, variable latency, redirects.
        lat_rand  = 1'b1;
        ready_pct = 70;
        repeat (400) begin
            @(negedge clk);
            #1;
            instr_take     = 1'($urandom_range(1));
            redirect_valid = ($urandom_range(24) == 0);
            redirect_pc    = $urandom;
        end
        redirect_valid = 1'b0;
        lat_rand  = 1'b0;
        ready_pct = 100;
        instr_take = 1'b1;
        repeat (10) @(negedge clk);

        // Asynchronous reset with requests in flight.
        mem_lat = 3;
        #1 instr_take = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1 if (pending.size() + int'(imem_resp_valid) >= 2) found = 1'b1;
        end
        check32("two_in_flight", 32'(found), 32'd1);
        #1 rst = 1'b0;
        pop_log.delete();
        #1;
        check32("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check32("arst_req_addr", imem_req_addr, RESET_PC);
        check32("arst_instr_valid", 32'(instr_valid), 32'd0);
        check32("arst_instr_out", instr_out, NOP);
        check32("arst_instr_pc", instr_pc_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        acc_log.delete();
        instr_take = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check_log("arst_first_addr", acc_log, 0, RESET_PC);
        check_log("arst_first_pop", pop_log, 0, RESET_PC);
        check_log("arst_second_pop", pop_log, 1, RESET_PC + 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
